// File: rtl/mem_stage_if.sv
// Execute / data-bus / writeback signal bundle for the memory stage.
// Handshakes: a transfer happens on a rising clk edge where valid (enable) and ready are both high.
// The sender keeps its payload stable until that edge.
interface mem_stage_if #(
  parameter int BUS_ADDR_WIDTH = 30
);
  // execute -> mem
  logic                      ready;
  logic                      enable;
  logic [4:0]                rd;
  logic [31:0]               next_pc;
  logic                      rd_value_write_enable;
  logic [31:0]               rd_value_write_data;
  logic                      is_load;
  logic                      is_store;
  logic [2:0]                funct3;
  logic [31:0]               mem_addr;
  logic [31:0]               store_data;
  // mem -> data bus
  logic                      bus_ready;
  logic                      bus_enable;
  logic                      bus_write;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]               bus_write_data;
  logic [3:0]                bus_byte_enable;
  logic [31:0]               bus_read_data;
  logic                      bus_read_data_valid;
  // mem -> writeback
  logic                      wb_ready;
  logic                      wb_enable;
  logic [4:0]                wb_rd;
  logic [31:0]               wb_next_pc;
  logic                      wb_rd_value_write_enable;
  logic [31:0]               wb_rd_value_write_data;
  logic                      wb_read_issued;
  // FSM state for observation (0 idle, 1 issue, 2 wait data)
  logic [1:0]                dbg_state;

  modport master (
    output ready,
    input  enable, rd, next_pc, rd_value_write_enable, rd_value_write_data,
    input  is_load, is_store, funct3, mem_addr, store_data,
    input  bus_ready, bus_read_data, bus_read_data_valid,
    output bus_enable, bus_write, bus_addr, bus_write_data, bus_byte_enable,
    input  wb_ready,
    output wb_enable, wb_rd, wb_next_pc, wb_rd_value_write_enable,
    output wb_rd_value_write_data, wb_read_issued,
    output dbg_state
  );

  modport slave (
    input  ready,
    output enable, rd, next_pc, rd_value_write_enable, rd_value_write_data,
    output is_load, is_store, funct3, mem_addr, store_data,
    output bus_ready, bus_read_data, bus_read_data_valid,
    input  bus_enable, bus_write, bus_addr, bus_write_data, bus_byte_enable,
    output wb_ready,
    input  wb_enable, wb_rd, wb_next_pc, wb_rd_value_write_enable,
    input  wb_rd_value_write_data, wb_read_issued,
    input  dbg_state
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: performs one load/store at a time on the data bus and
// hands a registered result to writeback.
module mem_stage #(
  parameter int BUS_ADDR_WIDTH = 30
) (
  input logic         clk,
  input logic         reset,
  mem_stage_if.master io
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [4:0]                rd_q, rd_d;
  logic [31:0]               next_pc_q, next_pc_d;
  logic                      wen_q, wen_d;
  logic [31:0]               alu_q, alu_d;
  logic                      is_load_q, is_load_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                off_q, off_d;
  logic                      bus_enable_q, bus_enable_d;
  logic                      bus_write_q, bus_write_d;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]               bus_wdata_q, bus_wdata_d;
  logic [3:0]                bus_be_q, bus_be_d;
  logic                      wb_enable_q, wb_enable_d;
  logic [4:0]                wb_rd_q, wb_rd_d;
  logic [31:0]               wb_next_pc_q, wb_next_pc_d;
  logic                      wb_wen_q, wb_wen_d;
  logic [31:0]               wb_data_q, wb_data_d;
  logic                      wb_read_issued_q, wb_read_issued_d;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  assign io.ready = (state_q == S_IDLE) && (!wb_enable_q || io.wb_ready);

  always_comb begin
    state_d          = state_q;
    rd_d             = rd_q;
    next_pc_d        = next_pc_q;
    wen_d            = wen_q;
    alu_d            = alu_q;
    is_load_d        = is_load_q;
    funct3_d         = funct3_q;
    off_d            = off_q;
    bus_enable_d     = bus_enable_q;
    bus_write_d      = bus_write_q;
    bus_addr_d       = bus_addr_q;
    bus_wdata_d      = bus_wdata_q;
    bus_be_d         = bus_be_q;
    wb_enable_d      = wb_enable_q;
    wb_rd_d          = wb_rd_q;
    wb_next_pc_d     = wb_next_pc_q;
    wb_wen_d         = wb_wen_q;
    wb_data_d        = wb_data_q;
    wb_read_issued_d = wb_read_issued_q;

    if (wb_enable_q && io.wb_ready) wb_enable_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io.enable && io.ready) begin
          rd_d      = io.rd;
          next_pc_d = io.next_pc;
          wen_d     = io.rd_value_write_enable;
          alu_d     = io.rd_value_write_data;
          is_load_d = io.is_load;
          funct3_d  = io.funct3;
          off_d     = io.mem_addr[1:0];
          if (io.is_load || io.is_store) begin
            state_d      = S_ISSUE;
            bus_enable_d = 1'b1;
            bus_write_d  = io.is_store;
            bus_addr_d   = io.mem_addr[BUS_ADDR_WIDTH+1:2];
            case (io.funct3)
              3'b000: begin
                bus_be_d    = 4'b0001 << io.mem_addr[1:0];
                bus_wdata_d = {4{io.store_data[7:0]}};
              end
              3'b001: begin
                bus_be_d    = io.mem_addr[1] ? 4'b1100 : 4'b0011;
                bus_wdata_d = {2{io.store_data[15:0]}};
              end
              default: begin
                bus_be_d    = 4'b1111;
                bus_wdata_d = io.store_data;
              end
            endcase
            if (io.is_load) bus_be_d = 4'b1111;
          end else begin
            wb_enable_d      = 1'b1;
            wb_rd_d          = io.rd;
            wb_next_pc_d     = io.next_pc;
            wb_wen_d         = io.rd_value_write_enable;
            wb_data_d        = io.rd_value_write_data;
            wb_read_issued_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (io.bus_ready) begin
          bus_enable_d = 1'b0;
          if (is_load_q) begin
            state_d = S_WAIT;
          end else begin
            // the ready rule guarantees the output register is empty here
            state_d          = S_IDLE;
            wb_enable_d      = 1'b1;
            wb_rd_d          = rd_q;
            wb_next_pc_d     = next_pc_q;
            wb_wen_d         = wen_q;
            wb_data_d        = alu_q;
            wb_read_issued_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (io.bus_read_data_valid) begin
          state_d          = S_IDLE;
          wb_enable_d      = 1'b1;
          wb_rd_d          = rd_q;
          wb_next_pc_d     = next_pc_q;
          wb_wen_d         = wen_q;
          wb_data_d        = format_load(funct3_q, off_q, io.bus_read_data);
          wb_read_issued_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      rd_q             <= '0;
      next_pc_q        <= '0;
      wen_q            <= 1'b0;
      alu_q            <= '0;
      is_load_q        <= 1'b0;
      funct3_q         <= '0;
      off_q            <= '0;
      bus_enable_q     <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
      bus_be_q         <= '0;
      wb_enable_q      <= 1'b0;
      wb_rd_q          <= '0;
      wb_next_pc_q     <= '0;
      wb_wen_q         <= 1'b0;
      wb_data_q        <= '0;
      wb_read_issued_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_q             <= rd_d;
      next_pc_q        <= next_pc_d;
      wen_q            <= wen_d;
      alu_q            <= alu_d;
      is_load_q        <= is_load_d;
      funct3_q         <= funct3_d;
      off_q            <= off_d;
      bus_enable_q     <= bus_enable_d;
      bus_write_q      <= bus_write_d;
      bus_addr_q       <= bus_addr_d;
      bus_wdata_q      <= bus_wdata_d;
      bus_be_q         <= bus_be_d;
      wb_enable_q      <= wb_enable_d;
      wb_rd_q          <= wb_rd_d;
      wb_next_pc_q     <= wb_next_pc_d;
      wb_wen_q         <= wb_wen_d;
      wb_data_q        <= wb_data_d;
      wb_read_issued_q <= wb_read_issued_d;
    end
  end

  assign io.bus_enable               = bus_enable_q;
  assign io.bus_write                = bus_write_q;
  assign io.bus_addr                 = bus_addr_q;
  assign io.bus_write_data           = bus_wdata_q;
  assign io.bus_byte_enable          = bus_be_q;
  assign io.wb_enable                = wb_enable_q;
  assign io.wb_rd                    = wb_rd_q;
  assign io.wb_next_pc               = wb_next_pc_q;
  assign io.wb_rd_value_write_enable = wb_wen_q;
  assign io.wb_rd_value_write_data   = wb_data_q;
  assign io.wb_read_issued           = wb_read_issued_q;
  assign io.dbg_state                = state_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, backpressure and reset.
module tb_mem_stage;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  mem_stage_if #(.BUS_ADDR_WIDTH(AW)) io();
  mem_stage #(.BUS_ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  // Inputs change at negedge; outputs are sampled there too, half a cycle after the active edge.
  task automatic idle_inputs();
    io.enable = 1'b0; io.rd = '0; io.next_pc = '0;
    io.rd_value_write_enable = 1'b0; io.rd_value_write_data = '0;
    io.is_load = 1'b0; io.is_store = 1'b0; io.funct3 = '0;
    io.mem_addr = '0; io.store_data = '0;
    io.bus_ready = 1'b0; io.bus_read_data = '0; io.bus_read_data_valid = 1'b0;
    io.wb_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    vec_cnt++; if (io.wb_enable !== 1'b0) begin err_cnt++; $display("FAIL rst_wb_enable: got %b exp 0", io.wb_enable); end
    vec_cnt++; if (io.bus_enable !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_enable: got %b exp 0", io.bus_enable); end
    vec_cnt++; if (io.dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d exp 0", io.dbg_state); end
    vec_cnt++; if (io.wb_rd_value_write_data !== 32'h0) begin err_cnt++; $display("FAIL rst_wb_data: got %h exp 0", io.wb_rd_value_write_data); end
    vec_cnt++; if (io.wb_next_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_wb_pc: got %h exp 0", io.wb_next_pc); end
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++; if (io.ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b exp 1", io.ready); end
  endtask

  task automatic test_alu();
    @(negedge clk);
    io.enable = 1'b1; io.rd = 5'd5; io.rd_value_write_data = 32'h1234_5678;
    io.rd_value_write_enable = 1'b1; io.next_pc = 32'h104;
    @(negedge clk);
    io.enable = 1'b0;
    vec_cnt++; if (io.wb_enable !== 1'b1) begin err_cnt++; $display("FAIL alu_wb_enable: got %b exp 1", io.wb_enable); end
    vec_cnt++; if (io.wb_rd !== 5'd5) begin err_cnt++; $display("FAIL alu_wb_rd: got %0d exp 5", io.wb_rd); end
    vec_cnt++; if (io.wb_rd_value_write_data !== 32'h1234_5678) begin err_cnt++; $display("FAIL alu_wb_data: got %h exp 12345678", io.wb_rd_value_write_data); end
    vec_cnt++; if (io.wb_next_pc !== 32'h104) begin err_cnt++; $display("FAIL alu_wb_pc: got %h exp 104", io.wb_next_pc); end
    vec_cnt++; if (io.wb_read_issued !== 1'b0) begin err_cnt++; $display("FAIL alu_read_issued: got %b exp 0", io.wb_read_issued); end
    vec_cnt++; if (io.wb_rd_value_write_enable !== 1'b1) begin err_cnt++; $display("FAIL alu_wb_we: got %b exp 1", io.wb_rd_value_write_enable); end
    vec_cnt++; if (io.ready !== 1'b1) begin err_cnt++; $display("FAIL alu_ready: got %b exp 1", io.ready); end
    @(negedge clk);
    vec_cnt++; if (io.wb_enable !== 1'b0) begin err_cnt++; $display("FAIL alu_drain: got %b exp 0", io.wb_enable); end
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [AW-1:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_data, input int hold);
    @(negedge clk);
    io.enable = 1'b1; io.is_store = 1'b1; io.funct3 = f3; io.mem_addr = addr;
    io.store_data = sdata; io.rd = 5'd0; io.rd_value_write_enable = 1'b0;
    io.next_pc = 32'h200; io.bus_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      io.enable = 1'b0; io.is_store = 1'b0;
      vec_cnt++; if (io.bus_enable !== 1'b1 || io.bus_write !== 1'b1) begin err_cnt++; $display("FAIL %s_bus_req[%0d]: got en=%b wr=%b exp en=1 wr=1", name, i, io.bus_enable, io.bus_write); end
      vec_cnt++; if (io.bus_addr !== exp_addr) begin err_cnt++; $display("FAIL %s_bus_addr[%0d]: got %h exp %h", name, i, io.bus_addr, exp_addr); end
      vec_cnt++; if (io.bus_byte_enable !== exp_be) begin err_cnt++; $display("FAIL %s_bus_be[%0d]: got %b exp %b", name, i, io.bus_byte_enable, exp_be); end
      vec_cnt++; if (io.bus_write_data !== exp_data) begin err_cnt++; $display("FAIL %s_bus_wdata[%0d]: got %h exp %h", name, i, io.bus_write_data, exp_data); end
      vec_cnt++; if (io.ready !== 1'b0 || io.wb_enable !== 1'b0) begin err_cnt++; $display("FAIL %s_busy[%0d]: got ready=%b wb_en=%b exp 0 0", name, i, io.ready, io.wb_enable); end
    end
    io.bus_ready = 1'b1;
    @(negedge clk);
    io.bus_ready = 1'b0;
    vec_cnt++; if (io.bus_enable !== 1'b0) begin err_cnt++; $display("FAIL %s_bus_drop: got %b exp 0", name, io.bus_enable); end
    vec_cnt++; if (io.wb_enable !== 1'b1 || io.wb_read_issued !== 1'b0) begin err_cnt++; $display("FAIL %s_wb: got en=%b ri=%b exp en=1 ri=0", name, io.wb_enable, io.wb_read_issued); end
    vec_cnt++; if (io.wb_rd_value_write_enable !== 1'b0 || io.wb_next_pc !== 32'h200) begin err_cnt++; $display("FAIL %s_wb_fields: got we=%b pc=%h exp we=0 pc=200", name, io.wb_rd_value_write_enable, io.wb_next_pc); end
    vec_cnt++; if (io.dbg_state !== 2'd0 || io.ready !== 1'b1) begin err_cnt++; $display("FAIL %s_idle: got st=%0d rdy=%b exp st=0 rdy=1", name, io.dbg_state, io.ready); end
    @(negedge clk);
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
    logic [AW-1:0] exp_addr;
    exp_addr = addr[AW+1:2];
    @(negedge clk);
    io.enable = 1'b1; io.is_load = 1'b1; io.funct3 = f3; io.mem_addr = addr;
    io.rd = 5'd7; io.rd_value_write_enable = 1'b1; io.next_pc = 32'h300; io.bus_ready = 1'b1;
    @(negedge clk);
    io.enable = 1'b0; io.is_load = 1'b0;
    vec_cnt++; if (io.bus_enable !== 1'b1 || io.bus_write !== 1'b0) begin err_cnt++; $display("FAIL %s_bus_req: got en=%b wr=%b exp en=1 wr=0", name, io.bus_enable, io.bus_write); end
    vec_cnt++; if (io.bus_addr !== exp_addr) begin err_cnt++; $display("FAIL %s_bus_addr: got %h exp %h", name, io.bus_addr, exp_addr); end
    vec_cnt++; if (io.bus_byte_enable !== 4'b1111) begin err_cnt++; $display("FAIL %s_bus_be: got %b exp 1111", name, io.bus_byte_enable); end
    @(negedge clk);
    io.bus_ready = 1'b0;
    vec_cnt++; if (io.bus_enable !== 1'b0 || io.dbg_state !== 2'd2) begin err_cnt++; $display("FAIL %s_wait: got en=%b st=%0d exp en=0 st=2", name, io.bus_enable, io.dbg_state); end
    @(negedge clk);
    vec_cnt++; if (io.wb_enable !== 1'b0 || io.ready !== 1'b0) begin err_cnt++; $display("FAIL %s_pending: got wb_en=%b rdy=%b exp 0 0", name, io.wb_enable, io.ready); end
    io.bus_read_data = rdata; io.bus_read_data_valid = 1'b1;
    @(negedge clk);
    io.bus_read_data_valid = 1'b0; io.bus_read_data = '0;
    vec_cnt++; if (io.wb_enable !== 1'b1 || io.wb_read_issued !== 1'b1) begin err_cnt++; $display("FAIL %s_wb: got en=%b ri=%b exp 1 1", name, io.wb_enable, io.wb_read_issued); end
    vec_cnt++; if (io.wb_rd_value_write_data !== exp_data) begin err_cnt++; $display("FAIL %s_data: got %h exp %h", name, io.wb_rd_value_write_data, exp_data); end
    vec_cnt++; if (io.wb_rd !== 5'd7 || io.wb_next_pc !== 32'h300) begin err_cnt++; $display("FAIL %s_fields: got rd=%0d pc=%h exp rd=7 pc=300", name, io.wb_rd, io.wb_next_pc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    io.enable = 1'b1; io.rd = 5'd1; io.rd_value_write_data = 32'h11; io.next_pc = 32'h4;
    @(negedge clk);
    vec_cnt++; if (io.ready !== 1'b1 || io.wb_rd !== 5'd1) begin err_cnt++; $display("FAIL b2b_first: got rdy=%b rd=%0d exp 1 1", io.ready, io.wb_rd); end
    io.rd = 5'd2; io.rd_value_write_data = 32'h22; io.next_pc = 32'h8;
    @(negedge clk);
    io.enable = 1'b0;
    vec_cnt++; if (io.wb_enable !== 1'b1 || io.wb_rd !== 5'd2 || io.wb_rd_value_write_data !== 32'h22) begin err_cnt++; $display("FAIL b2b_second: got en=%b rd=%0d data=%h exp 1 2 22", io.wb_enable, io.wb_rd, io.wb_rd_value_write_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    io.wb_ready = 1'b0;
    io.enable = 1'b1; io.rd = 5'd3; io.rd_value_write_data = 32'hDEAD_BEEF; io.next_pc = 32'h108;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io.rd = 5'd9; io.rd_value_write_data = 32'h99;
      vec_cnt++; if (io.wb_enable !== 1'b1 || io.wb_rd !== 5'd3 || io.wb_rd_value_write_data !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL bp_hold[%0d]: got en=%b rd=%0d data=%h exp 1 3 deadbeef", i, io.wb_enable, io.wb_rd, io.wb_rd_value_write_data); end
      vec_cnt++; if (io.ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, io.ready); end
    end
    io.enable = 1'b0; io.wb_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (io.wb_enable !== 1'b0 || io.ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release: got en=%b rdy=%b exp 0 1", io.wb_enable, io.ready); end
  endtask

  task automatic test_reset_mid();
    // reset while the bus request is outstanding
    @(negedge clk);
    io.enable = 1'b1; io.is_load = 1'b1; io.funct3 = 3'b010; io.mem_addr = 32'h40; io.bus_ready = 1'b0;
    @(negedge clk);
    io.enable = 1'b0; io.is_load = 1'b0;
    vec_cnt++; if (io.bus_enable !== 1'b1) begin err_cnt++; $display("FAIL rm_issue: got %b exp 1", io.bus_enable); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (io.bus_enable !== 1'b0 || io.dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rm_issue_rst: got en=%b st=%0d exp 0 0", io.bus_enable, io.dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    // reset while waiting for read data, then a late data beat
    @(negedge clk);
    io.enable = 1'b1; io.is_load = 1'b1; io.mem_addr = 32'h44; io.bus_ready = 1'b1;
    @(negedge clk);
    io.enable = 1'b0; io.is_load = 1'b0;
    @(negedge clk);
    io.bus_ready = 1'b0;
    vec_cnt++; if (io.dbg_state !== 2'd2) begin err_cnt++; $display("FAIL rm_wait: got %0d exp 2", io.dbg_state); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (io.wb_enable !== 1'b0 || io.bus_enable !== 1'b0 || io.dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rm_wait_rst: got wb=%b bus=%b st=%0d exp 0 0 0", io.wb_enable, io.bus_enable, io.dbg_state); end
    io.bus_read_data = 32'hFFFF_FFFF; io.bus_read_data_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    io.bus_read_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (io.wb_enable !== 1'b0 || io.ready !== 1'b1 || io.dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rm_after[%0d]: got wb=%b rdy=%b st=%0d exp 0 1 0", i, io.wb_enable, io.ready, io.dbg_state); end
      @(negedge clk);
    end
    // a result stuck under backpressure is discarded by reset
    io.wb_ready = 1'b0; io.enable = 1'b1; io.rd = 5'd4;
    @(negedge clk);
    io.enable = 1'b0;
    vec_cnt++; if (io.wb_enable !== 1'b1) begin err_cnt++; $display("FAIL rm_pending: got %b exp 1", io.wb_enable); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (io.wb_enable !== 1'b0) begin err_cnt++; $display("FAIL rm_discard: got %b exp 0", io.wb_enable); end
    @(negedge clk);
    reset = 1'b0; io.wb_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (io.wb_enable !== 1'b0 || io.ready !== 1'b1) begin err_cnt++; $display("FAIL rm_final: got wb=%b rdy=%b exp 0 1", io.wb_enable, io.ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store("sb", 3'b000, 32'h0000_1003, 32'h1234_56AB, 30'h400, 4'b1000, 32'hABAB_ABAB, 4);
    test_store("sh", 3'b001, 32'h0000_1006, 32'hCAFE_BEEF, 30'h401, 4'b1100, 32'hBEEF_BEEF, 1);
    test_store("sw", 3'b010, 32'h0000_1008, 32'hCAFE_BEEF, 30'h402, 4'b1111, 32'hCAFE_BEEF, 2);
    test_load("lb",  3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
    test_load("lb3", 3'b000, 32'h0000_2003, 32'h7F00_0000, 32'h0000_007F);
    test_load("lh",  3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
    test_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
    test_load("lw",  3'b010, 32'h0000_2002, 32'h8001_0000, 32'h8001_0000);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
